ahbl_to_apb3_bridge: RTL and testbench
======================================

Name: ahbl_to_apb3_bridge

Overview:
AHB-Lite slave to APB3 master bridge. It sits directly downstream of the AXI-to-AHB-Lite bridge and turns its 32-bit AHB-Lite transfers into single APB3 accesses for the low-speed peripheral bus (GPIO, UART, timer).
It runs on one clock. It adds registered wait states, an APB timeout, and a two-cycle AHB ERROR response.

Parameters:
PADDR_WIDTH, 16, width of PADDR; taken from HADDR[PADDR_WIDTH-1:0].
TIMEOUT_CYCLES, 255, maximum ACCESS cycles waiting for PREADY; 0 disables the timeout. Range 0..65535.

Ports:
HCLK  in  1  clock.
HRESETN  in  1  reset, synchronous, active-low.
HSEL  in  1  slave select.
HADDR  in  32  AHB address.
HTRANS  in  2  AHB transfer type.
HWRITE  in  1  AHB write.
HSIZE  in  3  AHB transfer size.
HBURST  in  3  ignored; each beat is handled as a single transfer.
HWDATA  in  32  write data, valid in the data phase.
HREADYIN  in  1  bus ready (previous transfer completing).
HREADYOUT  out  1  slave ready.
HRESP  out  1  0=OKAY, 1=ERROR.
HRDATA  out  32  read data.
PADDR  out  PADDR_WIDTH  APB address.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PWDATA  out  32  APB write data.
PRDATA  in  32  APB read data.
PREADY  in  1  APB ready.
PSLVERR  in  1  APB slave error.

Behaviour:
- Clock and reset: one clock, HCLK. Reset HRESETN is synchronous, active-low.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, state=IDLE, timeout count=0.
- Reset asserted mid-transfer: the next HCLK edge forces the reset values; the APB access is abandoned with no completion.
- Transfer-valid definition: valid = HSEL & HTRANS[1] & HREADYIN.
  - Sampled only in IDLE and ERR2.
  - When valid, HADDR, HWRITE and HSIZE are registered.
  - HTRANS IDLE/BUSY, or HSEL=0: no action; the data phase is zero-wait OKAY.
- State machine, one state per cycle:
  - IDLE: HREADYOUT=1, HRESP=0.
    - valid read -> SETUP.
    - valid write with HSIZE=010 -> WCAP.
    - valid write with HSIZE other than 010 -> ERR1; no APB access.
  - WCAP: HREADYOUT=0; PWDATA<=HWDATA; -> SETUP.
  - SETUP: PSEL=1, PENABLE=0; PADDR and PWRITE driven from the registered values; HREADYOUT=0; -> ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0; the timeout counter increments each cycle.
    - PREADY & !PSLVERR: HRDATA<=PRDATA on reads (held unchanged on writes); -> IDLE.
    - PREADY & PSLVERR: -> ERR1; HRDATA<=0 on reads.
    - !PREADY & TIMEOUT_CYCLES!=0 & count==TIMEOUT_CYCLES-1: -> ERR1.
  - ERR1: PSEL=0, PENABLE=0, HREADYOUT=0, HRESP=1; -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1; samples valid exactly as IDLE does, otherwise -> IDLE.
- Outputs: HREADYOUT, HRESP and all P* outputs are registered (decoded from state). PSEL and PENABLE drop in the cycle after the completing ACCESS cycle.
- Latency, data phase including the final HREADYOUT=1 cycle:
  - read: 3 cycles plus APB wait states.
  - word write: 4 cycles plus APB wait states.
  - sub-word write: 2-cycle error.
- Timeout counter: 16 bits; cleared on entry to SETUP; saturates, never wraps.
- PADDR: HADDR[PADDR_WIDTH-1:0] unchanged. Sub-word reads are issued as a full-word APB read with the address unaligned.
- Back-to-back transfers: the next address phase coincides with the IDLE/ERR2 cycle in which HREADYOUT=1. It is accepted in that same cycle, with no dead cycle.
- A master cancelling after ERR1 (driving HTRANS=IDLE in ERR2) produces no new APB access.

Decomposition:
- Package ahbl_apb_pkg holds:
  - state enum {IDLE, WCAP, SETUP, ACCESS, ERR1, ERR2};
  - HTRANS codes (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11);
  - HRESP_OKAY/HRESP_ERROR;
  - HSIZE_WORD=3'b010.
- One sub-module, apb_timeout_ctr: clear, enable, TIMEOUT_CYCLES parameter, expired output.

Test Plan:
1. Read 0x0000_0104, PRDATA=0xDEADBEEF, PREADY=1 immediately -> PSEL high 2 cycles, PENABLE 1 cycle, PADDR=0x0104; HRDATA=0xDEADBEEF with HREADYOUT=1 on the 3rd data-phase cycle, HRESP=0.
2. Word write 0x0000_0200 data 0x12345678, PREADY low 2 extra cycles -> PWDATA=0x12345678 stable through SETUP/ACCESS; ACCESS lasts 3 cycles; data phase 6 cycles, OKAY.
3. Read with PSLVERR=1 at completion -> HREADYOUT=0/HRESP=1 then HREADYOUT=1/HRESP=1, HRDATA=0.
4. Byte write (HSIZE=000) -> PSEL never asserts; two-cycle ERROR.
5. TIMEOUT_CYCLES=4, PREADY stuck 0 -> ACCESS exactly 4 cycles, PSEL drops, two-cycle ERROR. Repeat with TIMEOUT_CYCLES=0 for 1000 cycles -> HREADYOUT remains 0.
6. Back-to-back NONSEQ read then write; HRESETN low for 1 cycle during ACCESS of a third transfer -> the first two complete OKAY with no idle gap; after reset all outputs are at their reset values on the next edge.

Source files
------------

// File: rtl/ahbl_to_apb3_bridge_pkg.sv
// ----------------------------------------------------------------------------
// ahbl_apb_pkg
// Shared types and constants for the AHB-Lite to APB3 bridge:
//   - bridge state encoding
//   - AHB HTRANS / HRESP / HSIZE codes
//   - small decode helpers used by the bridge FSM
// ----------------------------------------------------------------------------
package ahbl_apb_pkg;

    // Bridge FSM states. One state per HCLK cycle of the AHB data phase.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WCAP   = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        ERR1   = 3'd4,
        ERR2   = 3'd5
    } state_e;

    // AHB HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // AHB HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Only full 32-bit writes can be forwarded; APB3 has no byte strobes.
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // NONSEQ and SEQ both carry bit 1 set; IDLE and BUSY never start work.
    function automatic logic is_active_trans(input logic [1:0] htrans);
        return htrans[1];
    endfunction

    // States in which the AHB side sees HREADYOUT high.
    function automatic logic state_ready(input state_e st);
        return (st == IDLE) || (st == ERR2);
    endfunction

    // States that make up the two-cycle ERROR response.
    function automatic logic state_error(input state_e st);
        return (st == ERR1) || (st == ERR2);
    endfunction

endpackage

// File: rtl/ahbl_to_apb3_bridge_if.sv
// ----------------------------------------------------------------------------
// ahbl_to_apb3_bridge_if
// Bundles the AHB-Lite slave port and APB3 master port of the bridge.
//   slave  modport : the bridge's view (AHB inputs in, HREADYOUT/HRESP/HRDATA
//                    out, APB requests out, PRDATA/PREADY/PSLVERR in)
//   master modport : the environment's view (AHB master + APB completer)
// ----------------------------------------------------------------------------
interface ahbl_to_apb3_bridge_if #(
    parameter int PADDR_WIDTH = 16
) ();

    // AHB-Lite side
    logic                   HSEL;
    logic [31:0]            HADDR;
    logic [1:0]             HTRANS;
    logic                   HWRITE;
    logic [2:0]             HSIZE;
    logic [2:0]             HBURST;
    logic [31:0]            HWDATA;
    logic                   HREADYIN;
    logic                   HREADYOUT;
    logic                   HRESP;
    logic [31:0]            HRDATA;

    // APB3 side
    logic [PADDR_WIDTH-1:0] PADDR;
    logic                   PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [31:0]            PWDATA;
    logic [31:0]            PRDATA;
    logic                   PREADY;
    logic                   PSLVERR;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYIN,
        output HREADYOUT, HRESP, HRDATA,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADYIN,
        input  HREADYOUT, HRESP, HRDATA,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/ahbl_to_apb3_bridge_timeout.sv
// ----------------------------------------------------------------------------
// apb_timeout_ctr
// Counts APB ACCESS cycles spent waiting for PREADY.
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : zero the count (asserted on entry to SETUP)
//   en         : count this cycle (asserted in ACCESS)
//   expired    : the current ACCESS cycle is the last one allowed
// The count is 16 bits and saturates. TIMEOUT_CYCLES = 0 disables expiry.
// ----------------------------------------------------------------------------
module apb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic        ENABLED = (TIMEOUT_CYCLES != 0);
    // Count value seen during the final permitted ACCESS cycle.
    localparam logic [15:0] LIMIT   = ENABLED ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: clear wins, otherwise increment until all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 16'd0;
        end else if (en && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = ENABLED && (count_q == LIMIT);

endmodule

// File: rtl/ahbl_to_apb3_bridge.sv
// ----------------------------------------------------------------------------
// ahbl_to_apb3_bridge
// AHB-Lite slave to APB3 master bridge. Each accepted AHB beat becomes one
// APB3 access; non-word writes are refused with a two-cycle ERROR response.
//   HCLK    : single clock
//   HRESETN : synchronous active-low reset
//   bus     : AHB-Lite slave + APB3 master signals (slave modport)
// All AHB response and APB request outputs come straight from flops that are
// loaded from the next-state decode, so they line up with the state register.
// ----------------------------------------------------------------------------
module ahbl_to_apb3_bridge
    import ahbl_apb_pkg::*;
#(
    parameter int PADDR_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         HCLK,
    input  logic                         HRESETN,
    ahbl_to_apb3_bridge_if.slave         bus
);

    state_e                 state_q,     state_d;
    logic [PADDR_WIDTH-1:0] addr_q,      addr_d;
    logic                   write_q,     write_d;
    logic [PADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic                   pwrite_q,    pwrite_d;
    logic [31:0]            pwdata_q,    pwdata_d;
    logic [31:0]            hrdata_q,    hrdata_d;
    logic                   hreadyout_q, hreadyout_d;
    logic                   hresp_q,     hresp_d;
    logic                   psel_q,      psel_d;
    logic                   penable_q,   penable_d;

    logic                   valid_s;
    logic                   ctr_clr_s;
    logic                   ctr_en_s;
    logic                   ctr_expired_s;

    apb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (HCLK),
        .rst_n   (HRESETN),
        .clr     (ctr_clr_s),
        .en      (ctr_en_s),
        .expired (ctr_expired_s)
    );

    // Next-state, captured transfer attributes and registered-output decode.
    always_comb begin
        valid_s   = bus.HSEL & is_active_trans(bus.HTRANS) & bus.HREADYIN;
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        hrdata_d  = hrdata_q;
        ctr_en_s  = 1'b0;

        case (state_q)
            // ERR2 shares the address-phase sampling of IDLE so that a
            // pipelined transfer behind an error is accepted without a gap.
            IDLE, ERR2: begin
                if (valid_s) begin
                    addr_d  = bus.HADDR[PADDR_WIDTH-1:0];
                    write_d = bus.HWRITE;
                    if (!bus.HWRITE) begin
                        state_d = SETUP;
                    end else if (bus.HSIZE == HSIZE_WORD) begin
                        state_d = WCAP;
                    end else begin
                        state_d = ERR1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            // HWDATA is only valid in the first data-phase cycle.
            WCAP: begin
                pwdata_d = bus.HWDATA;
                state_d  = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                ctr_en_s = 1'b1;
                if (bus.PREADY) begin
                    if (bus.PSLVERR) begin
                        state_d = ERR1;
                        if (!write_q) begin
                            hrdata_d = 32'd0;
                        end else begin
                            hrdata_d = hrdata_q;
                        end
                    end else begin
                        state_d = IDLE;
                        if (!write_q) begin
                            hrdata_d = bus.PRDATA;
                        end else begin
                            hrdata_d = hrdata_q;
                        end
                    end
                end else if (ctr_expired_s) begin
                    state_d = ERR1;
                end else begin
                    state_d = ACCESS;
                end
            end
            ERR1: begin
                state_d = ERR2;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // APB address/direction are loaded as SETUP is entered; addr_d already
        // holds the fresh HADDR when coming straight from an address phase.
        if (state_d == SETUP) begin
            paddr_d  = addr_d;
            pwrite_d = write_d;
        end else begin
            paddr_d  = paddr_q;
            pwrite_d = pwrite_q;
        end

        ctr_clr_s   = (state_d == SETUP) && (state_q != SETUP);

        hreadyout_d = state_ready(state_d);
        hresp_d     = state_error(state_d) ? HRESP_ERROR : HRESP_OKAY;
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            write_q     <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= 32'd0;
            hrdata_q    <= 32'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
        end
    end

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahbl_to_apb3_bridge.sv
// ----------------------------------------------------------------------------
// tb_ahbl_to_apb3_bridge
// Directed bench for the AHB-Lite to APB3 bridge. Instance A uses a 4-cycle
// APB timeout, instance B has the timeout disabled. Inputs change 1 time unit
// after the rising edge and outputs are checked at that same point.
// ----------------------------------------------------------------------------
module tb_ahbl_to_apb3_bridge;
    import ahbl_apb_pkg::*;

    logic HCLK;
    logic HRESETN;
    int   n_cmp;
    int   n_err;
    logic saw_ready;

    ahbl_to_apb3_bridge_if #(.PADDR_WIDTH(16)) ifa ();
    ahbl_to_apb3_bridge_if #(.PADDR_WIDTH(16)) ifb ();

    ahbl_to_apb3_bridge #(.PADDR_WIDTH(16), .TIMEOUT_CYCLES(4)) dut_a (
        .HCLK    (HCLK),
        .HRESETN (HRESETN),
        .bus     (ifa)
    );

    ahbl_to_apb3_bridge #(.PADDR_WIDTH(16), .TIMEOUT_CYCLES(0)) dut_b (
        .HCLK    (HCLK),
        .HRESETN (HRESETN),
        .bus     (ifb)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_a();
        ifa.HSEL   = 1'b0;
        ifa.HTRANS = HTRANS_IDLE;
    endtask

    task automatic addr_a(input logic [31:0] a, input logic w, input logic [2:0] sz);
        ifa.HSEL   = 1'b1;
        ifa.HTRANS = HTRANS_NONSEQ;
        ifa.HADDR  = a;
        ifa.HWRITE = w;
        ifa.HSIZE  = sz;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        HRESETN = 1'b0;
        ifa.HSEL = 1'b0;     ifa.HADDR = 32'd0;   ifa.HTRANS = HTRANS_IDLE;
        ifa.HWRITE = 1'b0;   ifa.HSIZE = 3'b010;  ifa.HBURST = 3'b000;
        ifa.HWDATA = 32'd0;  ifa.HREADYIN = 1'b1; ifa.PRDATA = 32'd0;
        ifa.PREADY = 1'b1;   ifa.PSLVERR = 1'b0;
        ifb.HSEL = 1'b0;     ifb.HADDR = 32'd0;   ifb.HTRANS = HTRANS_IDLE;
        ifb.HWRITE = 1'b0;   ifb.HSIZE = 3'b010;  ifb.HBURST = 3'b000;
        ifb.HWDATA = 32'd0;  ifb.HREADYIN = 1'b1; ifb.PRDATA = 32'd0;
        ifb.PREADY = 1'b1;   ifb.PSLVERR = 1'b0;

        // Reset values
        step(); step();
        chk("rst_hreadyout", {31'd0, ifa.HREADYOUT}, 32'd1);
        chk("rst_hresp",     {31'd0, ifa.HRESP},     32'd0);
        chk("rst_hrdata",    ifa.HRDATA,             32'd0);
        chk("rst_psel",      {31'd0, ifa.PSEL},      32'd0);
        chk("rst_penable",   {31'd0, ifa.PENABLE},   32'd0);
        chk("rst_pwrite",    {31'd0, ifa.PWRITE},    32'd0);
        chk("rst_paddr",     {16'd0, ifa.PADDR},     32'd0);
        chk("rst_pwdata",    ifa.PWDATA,             32'd0);
        HRESETN = 1'b1;
        step();
        chk("idle_ready", {31'd0, ifa.HREADYOUT}, 32'd1);

        // HTRANS=BUSY with HSEL=1: no action
        ifa.HSEL = 1'b1; ifa.HTRANS = HTRANS_BUSY;
        step();
        idle_a();
        chk("busy_psel",  {31'd0, ifa.PSEL},      32'd0);
        chk("busy_ready", {31'd0, ifa.HREADYOUT}, 32'd1);

        // Test 1: read 0x104, PREADY immediate
        addr_a(32'h0000_0104, 1'b0, 3'b010);
        ifa.PRDATA = 32'hDEAD_BEEF; ifa.PREADY = 1'b1;
        step(); idle_a();
        chk("t1_setup_psel",    {31'd0, ifa.PSEL},      32'd1);
        chk("t1_setup_penable", {31'd0, ifa.PENABLE},   32'd0);
        chk("t1_setup_ready",   {31'd0, ifa.HREADYOUT}, 32'd0);
        chk("t1_paddr",         {16'd0, ifa.PADDR},     32'h0000_0104);
        chk("t1_pwrite",        {31'd0, ifa.PWRITE},    32'd0);
        step();
        chk("t1_acc_psel",      {31'd0, ifa.PSEL},      32'd1);
        chk("t1_acc_penable",   {31'd0, ifa.PENABLE},   32'd1);
        chk("t1_acc_ready",     {31'd0, ifa.HREADYOUT}, 32'd0);
        step();
        chk("t1_done_ready",    {31'd0, ifa.HREADYOUT}, 32'd1);
        chk("t1_done_hresp",    {31'd0, ifa.HRESP},     32'd0);
        chk("t1_hrdata",        ifa.HRDATA,             32'hDEAD_BEEF);
        chk("t1_done_psel",     {31'd0, ifa.PSEL},      32'd0);
        chk("t1_done_penable",  {31'd0, ifa.PENABLE},   32'd0);

        // Test 2: word write 0x200, PREADY low for two extra ACCESS cycles
        addr_a(32'h0000_0200, 1'b1, 3'b010);
        step(); idle_a();
        ifa.HWDATA = 32'h1234_5678; ifa.PREADY = 1'b0;
        chk("t2_wcap_ready", {31'd0, ifa.HREADYOUT}, 32'd0);
        chk("t2_wcap_psel",  {31'd0, ifa.PSEL},      32'd0);
        step();
        ifa.HWDATA = 32'hFFFF_FFFF;
        chk("t2_setup_psel",    {31'd0, ifa.PSEL},    32'd1);
        chk("t2_setup_penable", {31'd0, ifa.PENABLE}, 32'd0);
        chk("t2_setup_pwdata",  ifa.PWDATA,           32'h1234_5678);
        chk("t2_pwrite",        {31'd0, ifa.PWRITE},  32'd1);
        chk("t2_paddr",         {16'd0, ifa.PADDR},   32'h0000_0200);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 2) ifa.PREADY = 1'b1;
            chk("t2_acc_penable", {31'd0, ifa.PENABLE},   32'd1);
            chk("t2_acc_ready",   {31'd0, ifa.HREADYOUT}, 32'd0);
            chk("t2_acc_pwdata",  ifa.PWDATA,             32'h1234_5678);
        end
        step();
        chk("t2_done_ready",  {31'd0, ifa.HREADYOUT}, 32'd1);
        chk("t2_done_hresp",  {31'd0, ifa.HRESP},     32'd0);
        chk("t2_done_psel",   {31'd0, ifa.PSEL},      32'd0);
        chk("t2_hrdata_held", ifa.HRDATA,             32'hDEAD_BEEF);

        // Test 3: read completing with PSLVERR
        addr_a(32'h0000_0300, 1'b0, 3'b010);
        ifa.PRDATA = 32'hCAFE_F00D; ifa.PSLVERR = 1'b1;
        step(); idle_a();
        step();
        step();
        ifa.PSLVERR = 1'b0;
        chk("t3_err1_ready",  {31'd0, ifa.HREADYOUT}, 32'd0);
        chk("t3_err1_hresp",  {31'd0, ifa.HRESP},     32'd1);
        chk("t3_err1_psel",   {31'd0, ifa.PSEL},      32'd0);
        chk("t3_hrdata_zero", ifa.HRDATA,             32'd0);
        step();
        chk("t3_err2_ready",  {31'd0, ifa.HREADYOUT}, 32'd1);
        chk("t3_err2_hresp",  {31'd0, ifa.HRESP},     32'd1);
        step();
        chk("t3_idle_hresp",  {31'd0, ifa.HRESP},     32'd0);

        // Test 4: byte write refused, no APB access
        addr_a(32'h0000_0400, 1'b1, 3'b000);
        step(); idle_a();
        ifa.HWDATA = 32'h5555_AAAA;
        chk("t4_err1_psel",  {31'd0, ifa.PSEL},      32'd0);
        chk("t4_err1_ready", {31'd0, ifa.HREADYOUT}, 32'd0);
        chk("t4_err1_hresp", {31'd0, ifa.HRESP},     32'd1);
        step();
        chk("t4_err2_psel",  {31'd0, ifa.PSEL},      32'd0);
        chk("t4_err2_ready", {31'd0, ifa.HREADYOUT}, 32'd1);
        chk("t4_err2_hresp", {31'd0, ifa.HRESP},     32'd1);
        step();
        chk("t4_pwdata_kept", ifa.PWDATA,            32'h1234_5678);
        chk("t4_idle_hresp",  {31'd0, ifa.HRESP},    32'd0);

        // Test 5a: timeout of 4 ACCESS cycles
        addr_a(32'h0000_0500, 1'b0, 3'b010);
        ifa.PREADY = 1'b0;
        step(); idle_a();
        chk("t5_setup_psel", {31'd0, ifa.PSEL}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_acc_penable", {31'd0, ifa.PENABLE},   32'd1);
            chk("t5_acc_ready",   {31'd0, ifa.HREADYOUT}, 32'd0);
        end
        step();
        chk("t5_err1_psel",    {31'd0, ifa.PSEL},      32'd0);
        chk("t5_err1_penable", {31'd0, ifa.PENABLE},   32'd0);
        chk("t5_err1_hresp",   {31'd0, ifa.HRESP},     32'd1);
        chk("t5_err1_ready",   {31'd0, ifa.HREADYOUT}, 32'd0);
        step();
        chk("t5_err2_ready",   {31'd0, ifa.HREADYOUT}, 32'd1);
        chk("t5_err2_hresp",   {31'd0, ifa.HRESP},     32'd1);
        ifa.PREADY = 1'b1;
        step();

        // Test 5b: timeout disabled, PREADY stuck low for 1000 cycles
        ifb.HSEL = 1'b1; ifb.HTRANS = HTRANS_NONSEQ; ifb.HADDR = 32'h0000_0700;
        ifb.HWRITE = 1'b0; ifb.HSIZE = 3'b010; ifb.PREADY = 1'b0;
        ifb.PRDATA = 32'h1111_2222;
        step();
        ifb.HSEL = 1'b0; ifb.HTRANS = HTRANS_IDLE;
        saw_ready = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            saw_ready = saw_ready | ifb.HREADYOUT;
        end
        chk("t5b_never_ready", {31'd0, saw_ready},    32'd0);
        chk("t5b_penable",     {31'd0, ifb.PENABLE},  32'd1);
        chk("t5b_paddr",       {16'd0, ifb.PADDR},    32'h0000_0700);
        ifb.PREADY = 1'b1;
        step();
        chk("t5b_done_ready",  {31'd0, ifb.HREADYOUT}, 32'd1);
        chk("t5b_hrdata",      ifb.HRDATA,             32'h1111_2222);

        // Test 6: back-to-back read then write, then reset during ACCESS
        addr_a(32'h0000_0600, 1'b0, 3'b010);
        ifa.PRDATA = 32'hA5A5_0001;
        step(); idle_a();
        step();
        step();
        chk("t6_rd_ready",  {31'd0, ifa.HREADYOUT}, 32'd1);
        chk("t6_rd_hrdata", ifa.HRDATA,             32'hA5A5_0001);
        addr_a(32'h0000_0604, 1'b1, 3'b010);
        step(); idle_a();
        ifa.HWDATA = 32'h0BAD_CAFE;
        chk("t6_wcap_ready", {31'd0, ifa.HREADYOUT}, 32'd0);
        step();
        chk("t6_wr_paddr",   {16'd0, ifa.PADDR},   32'h0000_0604);
        chk("t6_wr_pwdata",  ifa.PWDATA,           32'h0BAD_CAFE);
        chk("t6_wr_psel",    {31'd0, ifa.PSEL},    32'd1);
        step();
        step();
        chk("t6_wr_ready",   {31'd0, ifa.HREADYOUT}, 32'd1);
        chk("t6_wr_hresp",   {31'd0, ifa.HRESP},     32'd0);
        addr_a(32'h0000_0608, 1'b0, 3'b010);
        ifa.PREADY = 1'b0;
        step(); idle_a();
        step();
        chk("t6_third_penable", {31'd0, ifa.PENABLE}, 32'd1);
        HRESETN = 1'b0;
        step();
        HRESETN = 1'b1;
        chk("t6_rst_hreadyout", {31'd0, ifa.HREADYOUT}, 32'd1);
        chk("t6_rst_hresp",     {31'd0, ifa.HRESP},     32'd0);
        chk("t6_rst_hrdata",    ifa.HRDATA,             32'd0);
        chk("t6_rst_psel",      {31'd0, ifa.PSEL},      32'd0);
        chk("t6_rst_penable",   {31'd0, ifa.PENABLE},   32'd0);
        chk("t6_rst_pwrite",    {31'd0, ifa.PWRITE},    32'd0);
        chk("t6_rst_paddr",     {16'd0, ifa.PADDR},     32'd0);
        chk("t6_rst_pwdata",    ifa.PWDATA,             32'd0);
        step();
        chk("t6_post_psel",     {31'd0, ifa.PSEL},      32'd0);
        chk("t6_post_ready",    {31'd0, ifa.HREADYOUT}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
